// File: rtl/rec_pkg.sv
// Shared record layout, depth limit and parity helper for the rec_delay_pipe slice.
// The record is packed {x, y, z, w} with x in the MSB.
package rec_pkg;
  localparam int Y_W       = 4;
  localparam int W_W       = 2;
  localparam int REC_W     = 2 + Y_W + W_W;
  localparam int MAX_DEPTH = 16;

  typedef struct packed {
    logic           x;
    logic [Y_W-1:0] y;
    logic           z;
    logic [W_W-1:0] w;
  } rec_t;

  // Even parity: the bit that makes the total count of ones even.
  // Zero-extension of the argument does not change the result.
  function automatic logic rec_parity(input logic [63:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/rec_stage.sv
// One elastic pipeline slot: a valid bit plus an unreset data register.
// A slot loads from its predecessor when it is empty or when its successor takes its content.
module rec_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          prev_vld_i,
  input  logic [DW-1:0] prev_data_i,
  input  logic          nxt_adv_i,
  output logic          vld_o,
  output logic [DW-1:0] data_o,
  output logic          adv_o
);
  logic          vld_q, vld_d;
  logic [DW-1:0] data_q;

  assign adv_o  = !vld_q || nxt_adv_i;
  assign vld_o  = vld_q;
  assign data_o = data_q;

  always_comb begin
    vld_d = vld_q;
    if (flush_i)    vld_d = 1'b0;
    else if (adv_o) vld_d = prev_vld_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= 1'b0;
    else     vld_q <= vld_d;
  end

  // Contents are irrelevant while the slot is invalid, so no reset here.
  always_ff @(posedge clk) begin
    if (adv_o && prev_vld_i) data_q <= prev_data_i;
  end
endmodule

// File: rtl/rec_delay_pipe.sv
// Elastic DEPTH-stage record delay line with flush, occupancy count and optional parity.
// Define REC_DELAY_PARITY_EN to carry an even-parity bit with each record; in_rec/out_rec use the rec_pkg::rec_t layout.
module rec_delay_pipe
  import rec_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int Y_W   = rec_pkg::Y_W,
  parameter int W_W   = rec_pkg::W_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2+Y_W+W_W-1:0]       in_rec,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2+Y_W+W_W-1:0]       out_rec,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       out_perr
);
  localparam int RW    = 2 + Y_W + W_W;
  localparam int OCC_W = $clog2(DEPTH+1);
`ifdef REC_DELAY_PARITY_EN
  localparam int DW = RW + 1;
`else
  localparam int DW = RW;
`endif

  logic [DEPTH-1:0]         vld, adv, nxt_adv, prev_vld;
  logic [DEPTH-1:0][DW-1:0] data, prev_data;
  logic [DW-1:0]            stg_in;
  logic                     accept, emit;
  logic [OCC_W-1:0]         occ_q, occ_d;

`ifdef REC_DELAY_PARITY_EN
  assign stg_in   = {rec_parity(64'(in_rec)), in_rec};
  assign out_perr = out_valid && (rec_parity(64'(out_rec)) != data[DEPTH-1][RW]);
`else
  assign stg_in   = in_rec;
  assign out_perr = 1'b0;
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    if (i == 0) begin : g_head
      assign prev_vld[i]  = in_valid && !flush;
      assign prev_data[i] = stg_in;
    end else begin : g_body
      assign prev_vld[i]  = vld[i-1];
      assign prev_data[i] = data[i-1];
    end
    if (i == DEPTH-1) begin : g_tail
      assign nxt_adv[i] = out_ready;
    end else begin : g_mid
      assign nxt_adv[i] = adv[i+1];
    end

    rec_stage #(.DW(DW)) u_stg (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (flush),
      .prev_vld_i (prev_vld[i]),
      .prev_data_i(prev_data[i]),
      .nxt_adv_i  (nxt_adv[i]),
      .vld_o      (vld[i]),
      .data_o     (data[i]),
      .adv_o      (adv[i])
    );
  end

  assign in_ready  = adv[0] && !flush;
  assign out_valid = vld[DEPTH-1] && !flush;
  assign out_rec   = data[DEPTH-1][RW-1:0];
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;
  assign occupancy = occ_q;

  always_comb begin
    occ_d = occ_q + OCC_W'(accept) - OCC_W'(emit);
    if (flush) occ_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end
endmodule
